// File: rtl/spi_read_sequencer_pkg.sv
// ============================================================================
// Module  : spi_read_sequencer_pkg
// Brief   : Shared types and widths for the SPI read-request sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_read_sequencer_pkg;

  localparam int SS_W   = 2;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] ERR_DATA = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [SS_W-1:0]   ss;
    logic [ADDR_W-1:0] addr;
  } req_t;

endpackage

`default_nettype wire

// File: rtl/spi_read_sequencer_if.sv
// ============================================================================
// Module  : spi_read_sequencer_if
// Brief   : Request, master-device and response signals of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_read_sequencer_if #(
  parameter int DEPTH = 4
);
  import spi_read_sequencer_pkg::*;

  logic                         req_valid;
  logic                         req_ready;
  logic [SS_W-1:0]              req_ss;
  logic [ADDR_W-1:0]            req_addr;
  logic                         mst_start;
  logic [SS_W-1:0]              mst_ss_addr;
  logic [ADDR_W-1:0]            mst_data_addr;
  logic                         mst_done;
  logic [DATA_W-1:0]            mst_data;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [SS_W-1:0]              rsp_ss;
  logic [ADDR_W-1:0]            rsp_addr;
  logic [DATA_W-1:0]            rsp_data;
  logic                         rsp_err;
  logic [$clog2(DEPTH+1)-1:0]   count;

  // Sequencer side
  modport master (
    input  req_valid, req_ss, req_addr, mst_done, mst_data, rsp_ready,
    output req_ready, mst_start, mst_ss_addr, mst_data_addr,
           rsp_valid, rsp_ss, rsp_addr, rsp_data, rsp_err, count
  );

  // Requester / master-device / consumer side
  modport slave (
    output req_valid, req_ss, req_addr, mst_done, mst_data, rsp_ready,
    input  req_ready, mst_start, mst_ss_addr, mst_data_addr,
           rsp_valid, rsp_ss, rsp_addr, rsp_data, rsp_err, count
  );

endinterface

`default_nettype wire

// File: rtl/spi_read_sequencer_fifo.sv
// ============================================================================
// Module  : spi_read_sequencer_fifo
// Brief   : Synchronous request FIFO with wrap-around pointers and occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_read_sequencer_fifo
  import spi_read_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                       clk_i,
  input  wire logic                       rst_ni,
  input  wire logic                       push_i,
  input  wire logic                       pop_i,
  input  wire req_t                       wdata_i,
  output req_t                            rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]      count_o,
  output logic                            full_o,
  output logic                            empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_read_sequencer.sv
// ============================================================================
// Module  : spi_read_sequencer
// Brief   : Issues queued register reads to master_device one at a time and
//           returns each byte (or a timeout error) on a valid/ready port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_read_sequencer
  import spi_read_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  wire logic               clk_i,
  input  wire logic               rst_ni,
  spi_read_sequencer_if.master    bus
);

  localparam int TW = $clog2(TIMEOUT);

  state_e              state_q,    state_d;
  logic [TW-1:0]       timer_q,    timer_d;
  logic [SS_W-1:0]     mst_ss_q,   mst_ss_d;
  logic [ADDR_W-1:0]   mst_addr_q, mst_addr_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q,  rsp_err_d;

  req_t  head;
  req_t  wdata;
  logic  full;
  logic  empty;
  logic  push;
  logic  pop;

  // Ready is forced low while reset is held so every output reads 0 then.
  assign bus.req_ready = rst_ni & ~full;
  assign push          = bus.req_valid & bus.req_ready;
  assign pop           = (state_q == ST_RESP) & bus.rsp_ready;
  assign wdata.ss      = bus.req_ss;
  assign wdata.addr    = bus.req_addr;

  spi_read_sequencer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .count_o (bus.count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    mst_ss_d   = mst_ss_q;
    mst_addr_d = mst_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d    = ST_ISSUE;
          mst_ss_d   = head.ss;
          mst_addr_d = head.addr;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (bus.mst_done) begin
          state_d    = ST_RESP;
          rsp_data_d = bus.mst_data;
          rsp_err_d  = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
          if (timer_d == TW'(TIMEOUT-1)) begin
            state_d    = ST_RESP;
            rsp_data_d = ERR_DATA;
            rsp_err_d  = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      mst_ss_q   <= '0;
      mst_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mst_ss_q   <= mst_ss_d;
      mst_addr_q <= mst_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.mst_start     = (state_q == ST_ISSUE);
  assign bus.mst_ss_addr   = mst_ss_q;
  assign bus.mst_data_addr = mst_addr_q;
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_ss        = mst_ss_q;
  assign bus.rsp_addr      = mst_addr_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_read_sequencer.sv
// ============================================================================
// Module  : tb_spi_read_sequencer
// Brief   : Directed self-checking bench for spi_read_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_read_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   starts;

  spi_read_sequencer_if #(.DEPTH(4)) bus ();

  spi_read_sequencer #(
    .DEPTH   (4),
    .TIMEOUT (64)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mst_start) starts <= starts + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.mst_start && n < 200) begin
      tick();
      n++;
    end
    chk("start_seen", {31'd0, bus.mst_start}, 32'd1);
  endtask

  // Acts as the master: completes the current transaction `delay` cycles after START.
  task automatic serve(input logic [1:0] ss, input logic [7:0] addr,
                       input logic [7:0] data, input int delay);
    wait_start();
    chk("start_ss", {30'd0, bus.mst_ss_addr}, {30'd0, ss});
    chk("start_addr", {24'd0, bus.mst_data_addr}, {24'd0, addr});
    repeat (delay) tick();
    bus.mst_done = 1'b1;
    bus.mst_data = data;
    tick();
    bus.mst_done = 1'b0;
    chk("rsp_ok", {12'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_ss, bus.rsp_addr, bus.rsp_data},
                  {12'd0, 1'b1, 1'b0, ss, addr, data});
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  logic [1:0] fa_ss   [4];
  logic [7:0] fa_addr [4];
  logic [7:0] sw_addr [8];
  logic [7:0] sw_data [8];

  initial begin
    int s0;
    int n;
    checks = 0;
    errors = 0;
    starts = 0;
    fa_ss   = '{2'd0, 2'd1, 2'd3, 2'd2};
    fa_addr = '{8'h1A, 8'h2B, 8'h2A, 8'h2D};
    sw_addr = '{8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h2A, 8'h2B, 8'h2C, 8'h2D};
    sw_data = '{8'h41, 8'hDC, 8'h3B, 8'h4E, 8'h8C, 8'hB5, 8'h05, 8'hE5};

    // Reset
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_ss = '0; bus.req_addr = '0;
    bus.mst_done = 1'b0; bus.mst_data = '0; bus.rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_start", {31'd0, bus.mst_start}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    chk("rst_mst_addr", {22'd0, bus.mst_ss_addr, bus.mst_data_addr}, 32'd0);
    chk("rst_rsp", {13'd0, bus.rsp_err, bus.rsp_ss, bus.rsp_addr, bus.rsp_data}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", {31'd0, bus.req_ready}, 32'd1);

    // Single read: push at cycle 0, START at cycle 2, DONE 20 cycles later
    s0 = starts;
    bus.req_valid = 1'b1; bus.req_ss = 2'd2; bus.req_addr = 8'h1C;
    tick();
    bus.req_valid = 1'b0;
    chk("single_count", {29'd0, bus.count}, 32'd1);
    chk("single_no_start_c1", {31'd0, bus.mst_start}, 32'd0);
    tick();
    chk("single_start_c2", {31'd0, bus.mst_start}, 32'd1);
    chk("single_mst", {22'd0, bus.mst_ss_addr, bus.mst_data_addr}, {22'd0, 2'd2, 8'h1C});
    repeat (20) tick();
    chk("single_no_rsp_yet", {31'd0, bus.rsp_valid}, 32'd0);
    bus.mst_done = 1'b1; bus.mst_data = 8'h3B;
    tick();
    bus.mst_done = 1'b0;
    chk("single_rsp", {12'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_ss, bus.rsp_addr, bus.rsp_data},
                      {12'd0, 1'b1, 1'b0, 2'd2, 8'h1C, 8'h3B});
    chk("single_one_start", starts - s0, 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("single_popped", {28'd0, bus.rsp_valid, bus.count}, 32'd0);
    chk("idle_mst_held", {22'd0, bus.mst_ss_addr, bus.mst_data_addr}, {22'd0, 2'd2, 8'h1C});

    // Fill the queue with the master stalled
    s0 = starts;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_ss = fa_ss[i]; bus.req_addr = fa_addr[i];
      tick();
    end
    bus.req_ss = 2'd0; bus.req_addr = 8'h2C;
    chk("full_count", {29'd0, bus.count}, 32'd4);
    chk("full_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("full_one_start", starts - s0, 32'd1);
    chk("full_head_mst", {22'd0, bus.mst_ss_addr, bus.mst_data_addr}, {22'd0, fa_ss[0], fa_addr[0]});
    repeat (3) tick();
    chk("fifth_held", {29'd0, bus.count}, 32'd4);
    bus.mst_done = 1'b1; bus.mst_data = 8'hA7;
    tick();
    bus.mst_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_stable", {12'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_ss, bus.rsp_addr, bus.rsp_data},
                           {12'd0, 1'b1, 1'b0, fa_ss[0], fa_addr[0], 8'hA7});
      chk("bp_no_start", starts - s0, 32'd1);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("pop_no_push_when_full", {29'd0, bus.count}, 32'd3);
    tick();
    chk("fifth_accepted", {29'd0, bus.count}, 32'd4);
    bus.req_valid = 1'b0;
    serve(fa_ss[1], fa_addr[1], 8'h5A, 4);
    serve(fa_ss[2], fa_addr[2], 8'hC3, 63);
    serve(fa_ss[3], fa_addr[3], 8'h96, 1);
    serve(2'd0, 8'h2C, 8'h1E, 2);
    chk("drained", {29'd0, bus.count}, 32'd0);

    // Timeout with no DONE
    bus.req_valid = 1'b1; bus.req_ss = 2'd3; bus.req_addr = 8'h1D;
    tick();
    bus.req_valid = 1'b0;
    wait_start();
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, 32'd64);
    chk("timeout_rsp", {12'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_ss, bus.rsp_addr, bus.rsp_data},
                       {12'd0, 1'b1, 1'b1, 2'd3, 8'h1D, 8'h00});
    s0 = starts;
    bus.mst_done = 1'b1; bus.mst_data = 8'hFF;
    tick();
    bus.mst_done = 1'b0;
    chk("late_done_ignored", {12'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_ss, bus.rsp_addr, bus.rsp_data},
                             {12'd0, 1'b1, 1'b1, 2'd3, 8'h1D, 8'h00});
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.mst_done = 1'b1;
    tick();
    bus.mst_done = 1'b0;
    repeat (3) tick();
    chk("idle_done_ignored", {28'd0, bus.rsp_valid, bus.count}, 32'd0);
    chk("idle_no_start", starts - s0, 32'd0);

    // Reset while waiting for DONE
    s0 = starts;
    bus.req_valid = 1'b1; bus.req_ss = 2'd1; bus.req_addr = 8'h1B;
    tick();
    bus.req_valid = 1'b0;
    wait_start();
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_state", {27'd0, bus.mst_start, bus.rsp_valid, bus.count}, 32'd0);
    chk("midrst_mst", {22'd0, bus.mst_ss_addr, bus.mst_data_addr}, 32'd0);
    bus.mst_done = 1'b1; bus.mst_data = 8'h99;
    tick();
    bus.mst_done = 1'b0;
    repeat (5) tick();
    chk("midrst_no_rsp", {28'd0, bus.rsp_valid, bus.count}, 32'd0);
    chk("midrst_no_restart", starts - s0, 32'd1);

    // Sweep every slave across the register map
    s0 = starts;
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 8; a++) begin
        bus.req_valid = 1'b1; bus.req_ss = 2'(s); bus.req_addr = sw_addr[a];
        tick();
        bus.req_valid = 1'b0;
        serve(2'(s), sw_addr[a], sw_data[a], 2 + a);
      end
    end
    chk("sweep_starts", starts - s0, 32'd32);
    chk("sweep_empty", {29'd0, bus.count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
